// File: rtl/lane_arbiter_pkg.sv
// Shared lane/word geometry and the round-robin pick used by lane_arbiter.
package lane_arbiter_pkg;
  localparam int NUM_LANES = 4;
  localparam int DATA_W    = 8;
  localparam int VALID_BIT = 8;
  localparam int WORD_W    = DATA_W + 1;
  localparam int LANE_W    = $clog2(NUM_LANES);

  typedef struct packed {
    logic              found;
    logic [LANE_W-1:0] lane;
  } grant_t;

  // Scan from the farthest offset down so the lane nearest ptr is the last writer.
  function automatic grant_t rr_pick(input logic [NUM_LANES-1:0] req,
                                     input logic [LANE_W-1:0]    ptr);
    grant_t            g;
    logic [LANE_W-1:0] idx;
    g = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = ptr + LANE_W'(k);
      if (req[idx]) begin
        g.found = 1'b1;
        g.lane  = idx;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/lane_fifo.sv
// Per-lane circular FIFO with an occupancy count and registered full/empty flags.
module lane_fifo
  import lane_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              full_q, empty_q;
  logic              push_ok, pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (PTR_W + 1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;
endmodule

// File: rtl/lane_arbiter.sv
// Merges four lane FIFOs into one registered output stream with round-robin grant.
module lane_arbiter
  import lane_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    in_data0,
  input  logic [WORD_W-1:0]    in_data1,
  input  logic [WORD_W-1:0]    in_data2,
  input  logic [WORD_W-1:0]    in_data3,
  output logic [NUM_LANES-1:0] in_ready,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic [LANE_W-1:0]    out_lane,
  output logic [NUM_LANES-1:0] fifo_empty,
  output logic [NUM_LANES-1:0] fifo_full
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0]    lane_word [NUM_LANES];
  logic [DATA_W-1:0]    head      [NUM_LANES];
  logic [CNT_W-1:0]     count     [NUM_LANES];
  logic [NUM_LANES-1:0] push, pop, nonempty;

  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [LANE_W-1:0] out_lane_q, out_lane_d;
  logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              load;
  grant_t            grant;

  assign lane_word[0] = in_data0;
  assign lane_word[1] = in_data1;
  assign lane_word[2] = in_data2;
  assign lane_word[3] = in_data3;

  // The output slot is free when it holds no valid word or the sink takes it now.
  assign load  = ~out_data_q[VALID_BIT] | out_ready;
  assign grant = rr_pick(nonempty, rr_ptr_q);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign in_ready[i] = ~fifo_full[i] & ~reset;
    assign push[i]     = lane_word[i][VALID_BIT] & in_ready[i];
    assign pop[i]      = load & grant.found & (grant.lane == LANE_W'(i));
    assign nonempty[i] = (count[i] != '0);

    lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_4f),
      .rst   (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (lane_word[i][DATA_W-1:0]),
      .dout  (head[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .count (count[i])
    );
  end

  always_comb begin
    out_data_d = out_data_q;
    out_lane_d = out_lane_q;
    rr_ptr_d   = rr_ptr_q;
    if (load) begin
      if (grant.found) begin
        out_data_d = {1'b1, head[grant.lane]};
        out_lane_d = grant.lane;
        rr_ptr_d   = grant.lane + LANE_W'(1);
      end else begin
        out_data_d = {1'b0, out_data_q[DATA_W-1:0]};
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      out_data_q <= '0;
      out_lane_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      out_data_q <= out_data_d;
      out_lane_q <= out_lane_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_data = out_data_q;
  assign out_lane = out_lane_q;
endmodule

// File: tb/tb_lane_arbiter.sv
// Scoreboard bench for lane_arbiter: expected words queued at drive time, checked as they leave.
module tb_lane_arbiter;
  logic       clk_4f = 1'b0;
  logic       reset;
  logic [8:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_ready;
  logic [8:0] out_data;
  logic [1:0] out_lane;
  logic [3:0] fifo_empty, fifo_full;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] pay;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errs   = 0;
  logic [8:0] ew;
  logic [7:0] p;

  lane_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .in_data0   (in_data0),
    .in_data1   (in_data1),
    .in_data2   (in_data2),
    .in_data3   (in_data3),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic clr_inputs();
    in_data0 = '0;
    in_data1 = '0;
    in_data2 = '0;
    in_data3 = '0;
  endtask

  task automatic rst_pulse();
    reset     = 1'b1;
    out_ready = 1'b0;
    clr_inputs();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  // A valid word seen with out_ready high leaves the DUT at the next edge.
  always @(negedge clk_4f) begin
    if (!reset && out_data[8] && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 32'(out_data), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_lane", 32'(out_lane), 32'(mon_e.lane));
        chk("sb_data", 32'(out_data[7:0]), 32'(mon_e.pay));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    clr_inputs();
    tick();
    tick();
    chk("rst_out_data", 32'(out_data), 32'h000);
    chk("rst_out_lane", 32'(out_lane), 32'h0);
    chk("rst_empty", 32'(fifo_empty), 32'hF);
    chk("rst_full", 32'(fifo_full), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'hF);

    // Single word on lane 2, with latency and valid-drop afterwards.
    out_ready = 1'b1;
    in_data2  = 9'h1A5;
    sb.push_back('{lane: 2'd2, pay: 8'hA5});
    tick();
    in_data2 = '0;
    chk("no_bypass", 32'(out_data[8]), 32'h0);
    tick();
    chk("single_data", 32'(out_data), 32'h1A5);
    chk("single_lane", 32'(out_lane), 32'h2);
    tick();
    chk("single_after", 32'(out_data), 32'h0A5);
    chk("single_after_lane", 32'(out_lane), 32'h2);

    // All lanes, two words each: strict rotation.
    rst_pulse();
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_data0 = 9'h110;
      in_data1 = 9'h111;
      in_data2 = 9'h112;
      in_data3 = 9'h113;
      for (int i = 0; i < 4; i++) begin
        p = 8'h10 + 8'(i);
        sb.push_back('{lane: 2'(i), pay: p});
      end
      tick();
    end
    clr_inputs();
    repeat (10) tick();
    chk("rr_drained", 32'(sb.size()), 32'h0);
    chk("rr_empty", 32'(fifo_empty), 32'hF);

    // Lane 0 overfill while stalled.
    rst_pulse();
    for (int k = 0; k < 6; k++) begin
      p = 8'hA0 + 8'(k);
      in_data0 = {1'b1, p};
      if (k < 5) sb.push_back('{lane: 2'd0, pay: p});
      if (k == 5) begin
        chk("full_flag", 32'(fifo_full[0]), 32'h1);
        chk("full_in_ready", 32'(in_ready[0]), 32'h0);
        chk("full_out_data", 32'(out_data), 32'h1A0);
      end
      tick();
    end
    clr_inputs();
    chk("full_hold", 32'(fifo_full[0]), 32'h1);
    out_ready = 1'b1;
    repeat (8) tick();
    chk("full_drained", 32'(sb.size()), 32'h0);
    chk("full_empty_after", 32'(fifo_empty[0]), 32'h1);

    // Stall hold, then pop on the first ready edge.
    rst_pulse();
    in_data3 = 9'h1C3;
    sb.push_back('{lane: 2'd3, pay: 8'hC3});
    tick();
    in_data3 = 9'h1C4;
    sb.push_back('{lane: 2'd3, pay: 8'hC4});
    tick();
    clr_inputs();
    chk("stall_load", 32'(out_data), 32'h1C3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_data", 32'(out_data), 32'h1C3);
      chk("stall_lane", 32'(out_lane), 32'h3);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_resume", 32'(out_data), 32'h1C4);
    tick();
    chk("stall_idle", 32'(out_data), 32'h0C4);

    // Reset with words buffered in lanes 1 and 3 discards them.
    rst_pulse();
    for (int k = 0; k < 3; k++) begin
      p = 8'h60 + 8'(k);
      in_data1 = {1'b1, p};
      in_data3 = {1'b1, p};
      tick();
    end
    clr_inputs();
    chk("pre_rst_busy", 32'(out_data[8]), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_data", 32'(out_data), 32'h000);
    chk("mid_rst_empty", 32'(fifo_empty), 32'hF);
    chk("mid_rst_full", 32'(fifo_full), 32'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("no_stale", 32'(out_data), 32'h000);
    end

    // Lane 1 streaming: one in, one out per cycle.
    rst_pulse();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      p = 8'h50 + 8'(k);
      in_data1 = {1'b1, p};
      sb.push_back('{lane: 2'd1, pay: p});
      tick();
      chk("stream_nonempty", 32'(fifo_empty[1]), 32'h0);
      chk("stream_notfull", 32'(fifo_full[1]), 32'h0);
      if (k >= 1) begin
        ew = {1'b1, 8'h50 + 8'(k - 1)};
        chk("stream_data", 32'(out_data), 32'(ew));
      end
    end
    clr_inputs();
    tick();
    chk("stream_last", 32'(out_data), 32'h157);
    tick();
    chk("stream_idle", 32'(out_data), 32'h057);
    chk("stream_empty", 32'(fifo_empty), 32'hF);
    chk("final_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/lane_arbiter.md
LANE_ARBITER -- requirements
Module: lane_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning entries per lane FIFO (power of two, >=2).
REQ-002 clk_4f  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_data0..in_data3  input  9 each  lane words; bit 8 = valid, bits 7:0 = payload.
REQ-005 in_ready  output  4  bit i high = lane i can accept a word this cycle.
REQ-006 out_ready  input  1  downstream can take out_data this cycle.
REQ-007 out_data  output  9  merged stream; bit 8 = valid, bits 7:0 = payload.
REQ-008 out_lane  output  2  source lane of the current out_data word.
REQ-009 fifo_empty, fifo_full  output  4 each  per-lane FIFO status, registered.

Function
REQ-010 Lane i word accepted at an edge iff in_data_i[8]=1 and in_ready[i]=1; payload bits 7:0 are pushed into lane i FIFO.
REQ-011 in_ready[i] = ~fifo_full[i] & ~reset; a valid word presented with in_ready[i]=0 is dropped, with no other effect.
REQ-012 Output register loads at an edge iff out_data[8]=0 or out_ready=1; otherwise out_data and out_lane hold unchanged (stall).
REQ-013 On load, grant = first non-empty lane scanning rr_ptr, rr_ptr+1, ... mod 4; granted FIFO pops; out_data <= {1, head}; out_lane <= grant; rr_ptr <= grant+1 mod 4.
REQ-014 On load with all FIFOs empty: out_data <= {0, out_data[7:0]} (payload held, valid cleared); out_lane and rr_ptr unchanged.
REQ-015 Latency: word accepted at edge N into an empty FIFO, with its lane winning arbitration, appears on out_data after edge N+1; no bypass path.
REQ-016 Simultaneous push and pop on the same lane: both occur, occupancy unchanged, FIFO order preserved.
REQ-017 A full FIFO cannot be pushed in the same cycle it is popped; in_ready reflects the registered full flag only.
REQ-018 Pointers wrap modulo FIFO_DEPTH; full/empty derived from an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-019 Fairness: with all four lanes continuously non-empty and out_ready=1, grants rotate 0,1,2,3,0,... with one word per cycle.
REQ-020 out_data[8]=1 with out_ready=0 shall remain bit-identical until the accepting edge.

Reset
REQ-021 While reset=1 at an edge: all FIFOs emptied, rr_ptr=0, out_data=9'h000, out_lane=0, fifo_empty=4'hF, fifo_full=4'h0.
REQ-022 Reset mid-operation discards all buffered and in-flight words; no word accepted before reset appears afterward.
REQ-023 First acceptance possible at the first edge with reset=0.

Structure
REQ-024 Shared package holds NUM_LANES=4, DATA_W=8, VALID_BIT=8, and the lane-index width.
REQ-025 One sub-module lane_fifo (push, pop, data, full, empty, count), instantiated four times; arbiter and output register stay in lane_arbiter.

Verification
REQ-026 Reset, then in_data2=9'h1A5 for one cycle, out_ready=1 -> after the following edge out_data=9'h1A5, out_lane=2; next cycle out_data=9'h0A5.
REQ-027 All lanes push payloads 8'h10+i twice each in the same two cycles, out_ready=1 -> output lanes 0,1,2,3,0,1,2,3 with payloads 10,11,12,13,10,11,12,13.
REQ-028 Lane 0 pushes 5 words with out_ready=0 and FIFO_DEPTH=4 -> one word in the output register, 4 in the FIFO; in_ready[0]=0, fifo_full[0]=1; 6th word dropped; after releasing out_ready, exactly 5 words out in order.
REQ-029 out_ready=0 with out_data=9'h1C3 valid for 3 cycles -> out_data stays 9'h1C3, out_lane stable; pops resume on the first edge with out_ready=1.
REQ-030 Assert reset for 1 cycle with 3 words buffered in lanes 1 and 3 -> out_data=9'h000, fifo_empty=4'hF, no stale words emitted.
REQ-031 Lane 1 only, continuous push and pop with out_ready=1 -> fifo count constant at 1, one word output per cycle, in order.
